// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one Wishbone-classic slave port between the fetch and data masters.
// Data wins by default, a run counter guarantees fetch a slot, and a watchdog aborts hung transfers.
//
// state   | meaning
// IDLE    | no owner, bus outputs zero; arbitrates pending requests
// GNT_INS | fetch master owns the slave port
// GNT_DAT | data master owns the slave port
module bus_arbiter #(
   parameter int AWIDTH  = 32,
   parameter int DWIDTH  = 32,
   parameter int MAXRUN  = 4,
   parameter int TIMEOUT = 255
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ins_cyc_i,
   input  logic [AWIDTH-1:0]   ins_adr_i,
   output logic [DWIDTH-1:0]   ins_dat_o,
   output logic                ins_ack_o,
   output logic                ins_err_o,
   input  logic                dat_cyc_i,
   input  logic                dat_we_i,
   input  logic [DWIDTH/8-1:0] dat_sel_i,
   input  logic [AWIDTH-1:0]   dat_adr_i,
   input  logic [DWIDTH-1:0]   dat_dat_i,
   output logic [DWIDTH-1:0]   dat_dat_o,
   output logic                dat_ack_o,
   output logic                dat_err_o,
   output logic                bus_cyc_o,
   output logic                bus_we_o,
   output logic [DWIDTH/8-1:0] bus_sel_o,
   output logic [AWIDTH-1:0]   bus_adr_o,
   output logic [DWIDTH-1:0]   bus_dat_o,
   input  logic [DWIDTH-1:0]   bus_dat_i,
   input  logic                bus_ack_i,
   output logic [1:0]          owner_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_INS = 2'd1,
      GNT_DAT = 2'd2
   } state_t;

   localparam logic [3:0] RUN_MAX = 4'(MAXRUN);
   localparam logic [7:0] WD_MAX  = 8'(TIMEOUT);

   state_t     state;
   logic [3:0] run;
   logic [7:0] wdog;

   logic own_ins, own_dat, granted, expired, owner_cyc, done;

   assign own_ins   = (state == GNT_INS);
   assign own_dat   = (state == GNT_DAT);
   assign granted   = own_ins | own_dat;
   assign expired   = granted && (wdog == WD_MAX);
   assign owner_cyc = (own_ins & ins_cyc_i) | (own_dat & dat_cyc_i);
   assign done      = bus_ack_i | expired | ~owner_cyc;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         run   <= 4'd0;
         wdog  <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               // fetch only overrides data once data has used up its run allowance
               if (dat_cyc_i && !(ins_cyc_i && run == RUN_MAX)) begin
                  state <= GNT_DAT;
                  wdog  <= 8'd0;
                  run   <= ins_cyc_i ? run + 4'd1 : 4'd0;
               end else if (ins_cyc_i) begin
                  state <= GNT_INS;
                  wdog  <= 8'd0;
                  run   <= 4'd0;
               end
            end
            default: begin
               if (done) state <= IDLE;
               else      wdog  <= wdog + 8'd1;
            end
         endcase
      end
   end

   // ack beats a simultaneous timeout; cyc drops in the timeout cycle itself
   assign bus_cyc_o = granted & ~expired;
   assign bus_we_o  = own_dat & dat_we_i;
   assign bus_sel_o = own_ins ? '1 : (own_dat ? dat_sel_i : '0);
   assign bus_adr_o = own_ins ? ins_adr_i : (own_dat ? dat_adr_i : '0);
   assign bus_dat_o = own_dat ? dat_dat_i : '0;

   assign ins_dat_o = granted ? bus_dat_i : '0;
   assign dat_dat_o = granted ? bus_dat_i : '0;
   assign ins_ack_o = own_ins & bus_ack_i;
   assign dat_ack_o = own_dat & bus_ack_i;
   assign ins_err_o = own_ins & expired & ~bus_ack_i;
   assign dat_err_o = own_dat & expired & ~bus_ack_i;
   assign owner_o   = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with MAXRUN=4, TIMEOUT=8; inputs change 1ns after the rising edge.
module tb_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          ins_cyc_i;
   logic [AW-1:0] ins_adr_i;
   logic [DW-1:0] ins_dat_o;
   logic          ins_ack_o, ins_err_o;
   logic          dat_cyc_i, dat_we_i;
   logic [3:0]    dat_sel_i;
   logic [AW-1:0] dat_adr_i;
   logic [DW-1:0] dat_dat_i, dat_dat_o;
   logic          dat_ack_o, dat_err_o;
   logic          bus_cyc_o, bus_we_o;
   logic [3:0]    bus_sel_o;
   logic [AW-1:0] bus_adr_o;
   logic [DW-1:0] bus_dat_o, bus_dat_i;
   logic          bus_ack_i;
   logic [1:0]    owner_o;

   int n_chk = 0;
   int n_err = 0;

   bus_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MAXRUN(4), .TIMEOUT(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .ins_cyc_i(ins_cyc_i), .ins_adr_i(ins_adr_i), .ins_dat_o(ins_dat_o),
      .ins_ack_o(ins_ack_o), .ins_err_o(ins_err_o),
      .dat_cyc_i(dat_cyc_i), .dat_we_i(dat_we_i), .dat_sel_i(dat_sel_i),
      .dat_adr_i(dat_adr_i), .dat_dat_i(dat_dat_i), .dat_dat_o(dat_dat_o),
      .dat_ack_o(dat_ack_o), .dat_err_o(dat_err_o),
      .bus_cyc_o(bus_cyc_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
      .bus_adr_o(bus_adr_o), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
      .bus_ack_i(bus_ack_i), .owner_o(owner_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   logic [1:0] fair_exp [10] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   initial begin
      rst_i = 1'b0;
      ins_cyc_i = 1'b0; ins_adr_i = '0;
      dat_cyc_i = 1'b0; dat_we_i = 1'b0; dat_sel_i = '0; dat_adr_i = '0; dat_dat_i = '0;
      bus_dat_i = 32'hAAAA_5555; bus_ack_i = 1'b0;
      #3;
      chk("rst_owner", owner_o, 0);
      chk("rst_cyc", bus_cyc_o, 0);
      chk("rst_sel", bus_sel_o, 0);
      chk("rst_ins_dat", ins_dat_o, 0);
      chk("rst_dat_dat", dat_dat_o, 0);
      tick();
      rst_i = 1'b1;

      // reset in the middle of a granted data transfer
      dat_cyc_i = 1'b1; dat_adr_i = 32'h40; dat_sel_i = 4'hF;
      tick();
      chk("mid_owner_pre", owner_o, 2);
      chk("mid_cyc_pre", bus_cyc_o, 1);
      chk("mid_adr_pre", bus_adr_o, 32'h40);
      #2 rst_i = 1'b0;
      #1;
      chk("mid_cyc_async", bus_cyc_o, 0);
      chk("mid_owner_async", owner_o, 0);
      chk("mid_adr_async", bus_adr_o, 0);
      tick();
      rst_i = 1'b1;
      #2;
      chk("regrant_wait", owner_o, 0);
      tick();
      chk("regrant_owner", owner_o, 2);
      chk("regrant_cyc", bus_cyc_o, 1);
      dat_cyc_i = 1'b0;
      tick();
      chk("abandon_d_owner", owner_o, 0);

      // solo fetch, slave acks two cycles after cyc
      ins_cyc_i = 1'b1; ins_adr_i = 32'h100;
      dat_we_i = 1'b1; dat_sel_i = 4'h3; dat_adr_i = 32'h999;
      tick();
      chk("fetch_owner", owner_o, 1);
      chk("fetch_cyc", bus_cyc_o, 1);
      chk("fetch_adr", bus_adr_o, 32'h100);
      chk("fetch_we", bus_we_o, 0);
      chk("fetch_sel", bus_sel_o, 4'hF);
      chk("fetch_ack_early", ins_ack_o, 0);
      tick();
      tick();
      bus_ack_i = 1'b1; bus_dat_i = 32'hDEADBEEF;
      #1;
      chk("fetch_ack", ins_ack_o, 1);
      chk("fetch_rdata", ins_dat_o, 32'hDEADBEEF);
      chk("fetch_bcast", dat_dat_o, 32'hDEADBEEF);
      chk("fetch_dack", dat_ack_o, 0);
      chk("fetch_err", ins_err_o, 0);
      tick();
      ins_cyc_i = 1'b0; bus_ack_i = 1'b0;
      chk("fetch_idle", owner_o, 0);
      chk("fetch_idle_cyc", bus_cyc_o, 0);

      // simultaneous requests with run = 0: data first
      ins_cyc_i = 1'b1; ins_adr_i = 32'h300;
      dat_cyc_i = 1'b1; dat_we_i = 1'b1; dat_sel_i = 4'h3;
      dat_adr_i = 32'h2000; dat_dat_i = 32'h12345678;
      tick();
      chk("prio_owner", owner_o, 2);
      chk("prio_we", bus_we_o, 1);
      chk("prio_sel", bus_sel_o, 4'h3);
      chk("prio_adr", bus_adr_o, 32'h2000);
      chk("prio_wdata", bus_dat_o, 32'h12345678);
      bus_ack_i = 1'b1;
      #1;
      chk("prio_dack", dat_ack_o, 1);
      chk("prio_iack", ins_ack_o, 0);
      tick();
      dat_cyc_i = 1'b0; dat_we_i = 1'b0; bus_ack_i = 1'b0;
      chk("prio_gap", owner_o, 0);
      tick();
      chk("prio_fetch", owner_o, 1);
      chk("prio_fetch_adr", bus_adr_o, 32'h300);
      chk("prio_fetch_wdata", bus_dat_o, 0);
      bus_ack_i = 1'b1;
      tick();
      ins_cyc_i = 1'b0; bus_ack_i = 1'b0;

      // fairness: both masters request continuously, 1-cycle ack slave
      ins_cyc_i = 1'b1; dat_cyc_i = 1'b1; dat_sel_i = 4'hF;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("fair_grant%0d", i), owner_o, fair_exp[i]);
         bus_ack_i = 1'b1;
         tick();
         bus_ack_i = 1'b0;
         chk($sformatf("fair_idle%0d", i), owner_o, 0);
      end
      ins_cyc_i = 1'b0; dat_cyc_i = 1'b0;
      tick();

      // timeout: slave never acks
      dat_cyc_i = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("to_cyc%0d", k), bus_cyc_o, 1);
         chk($sformatf("to_noerr%0d", k), dat_err_o, 0);
         tick();
      end
      chk("to_err", dat_err_o, 1);
      chk("to_cyc_drop", bus_cyc_o, 0);
      chk("to_ins_err", ins_err_o, 0);
      tick();
      dat_cyc_i = 1'b0;
      chk("to_idle", owner_o, 0);
      chk("to_err_clear", dat_err_o, 0);

      // ack arriving in the timeout cycle wins
      dat_cyc_i = 1'b1;
      tick();
      for (int k = 0; k < 8; k++) tick();
      bus_ack_i = 1'b1;
      #1;
      chk("tie_ack", dat_ack_o, 1);
      chk("tie_noerr", dat_err_o, 0);
      tick();
      dat_cyc_i = 1'b0; bus_ack_i = 1'b0;
      chk("tie_idle", owner_o, 0);

      // fetch abandons its cycle; late ack in IDLE is ignored
      ins_cyc_i = 1'b1;
      tick();
      chk("ab_owner", owner_o, 1);
      ins_cyc_i = 1'b0;
      #1;
      chk("ab_ack", ins_ack_o, 0);
      chk("ab_err", ins_err_o, 0);
      tick();
      chk("ab_idle", owner_o, 0);
      bus_ack_i = 1'b1;
      #1;
      chk("late_iack", ins_ack_o, 0);
      chk("late_dack", dat_ack_o, 0);
      chk("late_cyc", bus_cyc_o, 0);
      tick();
      chk("late_owner", owner_o, 0);
      bus_ack_i = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
